// File: rtl/approx_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// approx_cmp_arbiter : round-robin shared MSB-only magnitude comparator with
//                      a single-entry valid/ready result slot.
// Revision: 1.0
// ============================================================================
module approx_cmp_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int IGN_LSB = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_eq,
    output logic                      rsp_gt,
    output logic                      rsp_lt,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    localparam int                c_ID_W     = $clog2(NREQ);
    localparam logic [c_ID_W:0]   c_NREQ_EXT = (c_ID_W+1)'(NREQ);
    localparam logic [c_ID_W-1:0] c_LAST     = c_ID_W'(NREQ-1);
    localparam logic [0:0]        c_EMPTY    = 1'b0;
    localparam logic [0:0]        c_FULL     = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [c_ID_W-1:0]    r_ptr;
    logic [c_ID_W-1:0]    r_id;
    logic                 r_eq;
    logic                 r_gt;
    logic                 r_lt;
    logic [CNT_W-1:0]     r_cnt;
    logic [c_ID_W-1:0]    w_gnt_idx;
    logic [c_ID_W:0]      w_sum;
    logic                 w_found;
    logic                 w_can_accept;
    logic                 w_accept;
    logic [W-1:0]         w_a;
    logic [W-1:0]         w_b;
    logic [W-IGN_LSB-1:0] w_a_m;
    logic [W-IGN_LSB-1:0] w_b_m;

    // Rotating search: candidate index is (ptr + k) mod NREQ, found by one conditional subtract.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W+1)'(k);
            if (w_sum >= c_NREQ_EXT) begin
                w_sum = w_sum - c_NREQ_EXT;
            end
            if (!w_found && req_valid[w_sum[c_ID_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_sum[c_ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == c_ID_W'(i)) begin
                w_a = req_a[i*W +: W];
                w_b = req_b[i*W +: W];
            end
        end
    end

    assign w_a_m        = w_a[W-1:IGN_LSB];
    assign w_b_m        = w_b[W-1:IGN_LSB];
    assign w_can_accept = (r_state == c_EMPTY) || rsp_ready;
    assign w_accept     = w_found && w_can_accept && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_EMPTY: if (w_accept) w_state_next = c_FULL;
            c_FULL:  if (!w_accept && rsp_ready) w_state_next = c_EMPTY;
            default: w_state_next = c_EMPTY;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
        rsp_valid = (r_state == c_FULL);
        rsp_id    = r_id;
        rsp_eq    = rsp_valid && r_eq;
        rsp_gt    = rsp_valid && r_gt;
        rsp_lt    = rsp_valid && r_lt;
        busy      = rsp_valid || (|req_valid);
        op_count  = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + c_ID_W'(1);
                r_id  <= w_gnt_idx;
                r_eq  <= (w_a_m == w_b_m);
                r_gt  <= (w_a_m >  w_b_m);
                r_lt  <= (w_a_m <  w_b_m);
            end
            // Counter sticks at all-ones instead of wrapping.
            if ((r_state == c_FULL) && rsp_ready && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// tb_approx_cmp_arbiter : directed scoreboard bench for approx_cmp_arbiter.
// Revision: 1.0
// ============================================================================
module tb_approx_cmp_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 4;
    localparam int IGN   = 2;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_ready;

    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic              rsp_eq, rsp_gt, rsp_lt, busy;
    logic [CNT_W-1:0]  op_count;

    logic [NREQ-1:0]   s_req_ready;
    logic              s_rsp_valid;
    logic [1:0]        s_rsp_id;
    logic              s_rsp_eq, s_rsp_gt, s_rsp_lt, s_busy;
    logic [1:0]        s_op_count;

    typedef struct packed {
        logic [1:0] id;
        logic       eq;
        logic       gt;
        logic       lt;
    } exp_t;

    exp_t q[$];
    int   m_ptr, m_cnt, m_cnt2;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    approx_cmp_arbiter #(.NREQ(NREQ), .W(W), .IGN_LSB(IGN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
        .busy(busy), .op_count(op_count)
    );

    approx_cmp_arbiter #(.NREQ(NREQ), .W(W), .IGN_LSB(IGN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(s_rsp_id), .rsp_eq(s_rsp_eq), .rsp_gt(s_rsp_gt), .rsp_lt(s_rsp_lt),
        .busy(s_busy), .op_count(s_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] am, bm;
        am   = a >> IGN;
        bm   = b >> IGN;
        e.id = 2'(id);
        e.eq = (am == bm);
        e.gt = (am >  bm);
        e.lt = (am <  bm);
        return e;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: check outputs at the falling edge, then advance the reference at the rising edge.
    task automatic step(input string tag);
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        bit              can;
        @(negedge clk);
        g       = -1;
        exp_rdy = '0;
        can     = (q.size() == 0) || rsp_ready;
        if (!rst && can) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(q[0].id));
            chk({tag, ".flags"}, 32'({rsp_eq, rsp_gt, rsp_lt}), 32'({q[0].eq, q[0].gt, q[0].lt}));
        end else begin
            chk({tag, ".flags_idle"}, 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(0));
        end
        chk({tag, ".busy"}, 32'(busy), 32'((q.size() != 0) || (|req_valid)));
        chk({tag, ".op_count"}, 32'(op_count), 32'(m_cnt));
        chk({tag, ".op_count_sat"}, 32'(s_op_count), 32'(m_cnt2));
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr  = 0;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (q.size() != 0 && rsp_ready) begin
                void'(q.pop_front());
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (g >= 0) begin
                q.push_back(model(g, req_a[g*W +: W], req_b[g*W +: W]));
                m_ptr = (g + 1) % NREQ;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp6 [5];
        exp6 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        m_ptr = 0; m_cnt = 0; m_cnt2 = 0;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        step("reset");
        chk("reset.rsp_id", 32'(rsp_id), 32'(0));

        // Basic single request, approximate equality
        rst = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0001;
        set_op(0, 4'b1000, 4'b1001);
        #1 chk("t1.grant", 32'(req_ready), 32'(4'b0001));
        step("t1a");
        chk("t1.id", 32'(rsp_id), 32'(0));
        chk("t1.eqgtlt", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(3'b100));
        req_valid = '0;
        step("t1b");
        chk("t1.count", 32'(op_count), 32'(1));

        // Flag patterns through requester 2
        req_valid = 4'b0100;
        set_op(2, 4'b0011, 4'b1011); step("t2_lt");
        chk("t2.lt", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(3'b001));
        set_op(2, 4'b1010, 4'b0110); step("t2_gt");
        set_op(2, 4'b1100, 4'b1111); step("t2_eq");
        set_op(2, 4'b1111, 4'b0000); step("t2_gt2");
        req_valid = '0;
        step("t2_drain");

        // Round-robin rotation from a fresh pointer
        rst = 1'b1; step("t3_rst");
        rst = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i * 4), 4'(15 - i * 4));
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3.rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
            step("t3_rr");
            chk("t3.rr_id", 32'(rsp_id), 32'(i % 4));
        end
        req_valid = '0;
        step("t3_drain");

        // Backpressure then release with no bubble
        rsp_ready = 1'b0; req_valid = 4'b0001; set_op(0, 4'b0100, 4'b1000);
        step("t4_acc0");
        req_valid = 4'b0010; set_op(1, 4'b1110, 4'b0001);
        for (int i = 0; i < 3; i++) step("t4_hold");
        rsp_ready = 1'b1;
        #1 chk("t4.release_grant", 32'(req_ready), 32'(4'b0010));
        step("t4_rel");
        chk("t4.next_id", 32'(rsp_id), 32'(1));
        req_valid = '0;
        step("t4_drain");

        // Reset while a result is pending
        rsp_ready = 1'b0; req_valid = 4'b0001;
        step("t5_acc");
        req_valid = 4'b1001; rst = 1'b1;
        step("t5_rst");
        rst = 1'b0;
        chk("t5.valid_cleared", 32'(rsp_valid), 32'(0));
        chk("t5.count_cleared", 32'(op_count), 32'(0));
        #1 chk("t5.prio0", 32'(req_ready), 32'(4'b0001));
        step("t5_after");
        req_valid = '0; rsp_ready = 1'b1;
        step("t5_drain");

        // Saturating counter on the narrow-counter instance
        rst = 1'b1; step("t6_rst");
        rst = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0001;
        step("t6_first");
        for (int k = 0; k < 5; k++) begin
            step("t6_run");
            chk("t6.sat_count", 32'(s_op_count), 32'(exp6[k]));
        end
        req_valid = '0;
        step("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
